conv_res_collector: RTL and testbench
=====================================

// Module: conv_res_collector
// PURPOSE
//  Sink for the bonus_conv result stream. Captures one streamed frame (default 8x10 signed results),
//  row-major, into an internal buffer. Frame ends on element count or conv_done. On request, replays
//  the frame through a valid/ready port to the display/UART path with row/col tags.
//  Sits between bonus_conv (conv_res_data/valid/done) and the output formatter.
// PARAMETERS
//  ROWS  8   result rows per frame
//  COLS  10  result columns per frame
//  DW    16  result data width (two's complement)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  clr         in   1   synchronous clear: abort any state, return to IDLE, zero count and flags
//  in_data     in   DW  result sample (driven by conv_res_data)
//  in_valid    in   1   sample strobe, one sample per high cycle (driven by conv_res_valid)
//  in_done     in   1   end-of-convolution pulse (driven by conv_done)
//  start_dump  in   1   one-cycle request to replay the captured frame
//  out_data    out  DW  replayed sample
//  out_row     out  3   row index of out_data
//  out_col     out  4   column index of out_data
//  out_valid   out  1   out_data/out_row/out_col valid
//  out_ready   in   1   downstream accepts when out_valid && out_ready
//  out_last    out  1   high with the final element of the frame
//  frame_rdy   out  1   frame captured, dump may be requested (state FULL)
//  count       out  7   samples captured in current/last frame (0..ROWS*COLS)
//  short_frame out  1   sticky: in_done closed frame with count < ROWS*COLS
//  overflow    out  1   sticky: in_valid seen while FULL or DUMP (sample dropped)
// BEHAVIOUR
//  Reset (rst_n=0) or clr: state IDLE; all outputs 0; count 0; sticky flags 0. clr beats every other input.
//  States: IDLE -> CAPTURE on first in_valid (that sample is stored at index 0).
//   CAPTURE: each in_valid writes buf[count], count++; wr col wraps at COLS-1 to 0 and bumps row.
//   CAPTURE -> FULL when count reaches ROWS*COLS, or on in_done (same-cycle in_valid is stored first).
//   in_done with count<ROWS*COLS sets short_frame. in_done in IDLE is ignored (no empty frames).
//   FULL: frame_rdy=1; start_dump -> DUMP; start_dump in any other state is ignored.
//   DUMP: elements 0..count-1 replayed in row-major order; out_valid rises 2 cycles after start_dump.
//   Full throughput: one element per cycle while out_ready held high.
//   While out_valid && !out_ready, out_data/out_row/out_col/out_last are held stable. out_valid never drops until accepted.
//   out_last=1 only on element count-1; its acceptance -> FULL (frame retained, re-dump allowed).
//   in_valid in FULL/DUMP: sample dropped, overflow=1; buffer unchanged. New frame only after clr.
//  Indices: out_row = idx / COLS, out_col = idx % COLS, kept as counters (no divider).
//  Data stored unmodified (see CONFIGURATION). No arithmetic on values otherwise.
// CONFIGURATION
//  CONV_RES_CLIP_EN defined: on capture each sample is saturated to signed 8-bit [-128,127], then sign-extended to DW (for 7-seg/LED display).
//   Example: 300 -> 127, -200 -> -128, 5 -> 5.
//  Undefined: samples stored and replayed bit-exact.
// STRUCTURE
//  conv_defs.vh: ROWS/COLS defaults, state encodings (IDLE, CAPTURE, FULL, DUMP), ROWS*COLS constant.
//   Also used by bonus_conv and the formatter.
//  Sub-module conv_res_ram: ROWS*COLS x DW simple dual-port, sync write, 1-cycle registered read.
//  Top holds FSM, wr/rd row-col counters, and a 1-entry output skid register for valid/ready.
// TESTING
//  1 Stream 80 samples v=i-40 (i=0..79), then in_done -> count=80, frame_rdy=1, short_frame=0, overflow=0.
//  2 start_dump with out_ready=1 -> out_valid at +2 cycles, 80 consecutive beats, (row,col) (0,0)..(7,9),
//    data i-40, out_last only on (7,9).
//  3 Dump with out_ready toggled pseudo-randomly -> no loss or duplication; outputs stable while stalled.
//  4 30 samples then in_done (same cycle as 30th valid) -> count=30, short_frame=1, last element is (2,9).
//  5 After FULL, 3 extra in_valid -> overflow=1, re-dump matches original. clr -> IDLE, count=0, flags 0.
//  6 rst_n low mid-DUMP -> out_valid=0 at once. With CONV_RES_CLIP_EN, inputs 300/-200 replay as 127/-128.

Source files
------------

// File: rtl/conv_res_collector_pkg.sv
// Shared definitions for the convolution result collector: frame geometry
// defaults, the collector state encoding and a width helper.
package conv_res_collector_pkg;

    localparam int ROWS_DEFAULT  = 8;
    localparam int COLS_DEFAULT  = 10;
    localparam int DW_DEFAULT    = 16;
    localparam int FRAME_DEFAULT = ROWS_DEFAULT * COLS_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2,
        ST_DUMP    = 2'd3
    } collectorState_t;

    // Bits needed to index n items, never less than one bit.
    function automatic int widthOf(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_res_collector_ram.sv
// Frame buffer for the result collector: simple dual-port memory with a
// synchronous write port and a registered read port. The read register only
// updates when i_rdEn is high, so it can hold one element while the output
// stage is stalled.
module conv_res_collector_ram
    import conv_res_collector_pkg::*;
#(
    parameter  int DEPTH = FRAME_DEFAULT,
    parameter  int DW    = DW_DEFAULT,
    localparam int AW    = widthOf(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_wrEn,
    input  logic [AW-1:0] i_wrAddr,
    input  logic [DW-1:0] i_wrData,
    input  logic          i_rdEn,
    input  logic [AW-1:0] i_rdAddr,
    output logic [DW-1:0] o_rdData
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdData;

    // Store one captured sample per write strobe.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Registered read; holds its value while no read is requested.
    always_ff @(posedge i_clk) begin
        if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/conv_res_collector.sv
// Convolution result collector. Captures one row-major frame from the
// bonus_conv result stream into a buffer and replays it with row/column tags
// through a valid/ready port.
// Optional feature: define CONV_RES_CLIP_EN to saturate every captured sample
// to the signed 8-bit range before storing it (for the 7-seg/LED display path).
// Replay pipeline: RAM read register (stage 1) feeding a one-entry output
// register (stage 2); reads are only issued when stage 1 is empty or is being
// drained, which gives one element per cycle with no bubbles.
module conv_res_collector
    import conv_res_collector_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic [DW-1:0]                   in_data,
    input  logic                            in_valid,
    input  logic                            in_done,
    input  logic                            start_dump,
    output logic [DW-1:0]                   out_data,
    output logic [widthOf(ROWS)-1:0]        out_row,
    output logic [widthOf(COLS)-1:0]        out_col,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            frame_rdy,
    output logic [widthOf(ROWS*COLS+1)-1:0] count,
    output logic                            short_frame,
    output logic                            overflow
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = widthOf(DEPTH);
    localparam int NW    = widthOf(DEPTH + 1);
    localparam int RW    = widthOf(ROWS);
    localparam int CLW   = widthOf(COLS);

    localparam logic [NW-1:0]  DEPTH_N  = NW'(DEPTH);
    localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);

    collectorState_t r_state;
    collectorState_t w_stateNext;

    logic [NW-1:0]  r_count;
    logic [NW-1:0]  w_countInc;
    logic           r_shortFrame;
    logic           r_overflow;
    logic           w_setShort;
    logic           w_setOverflow;
    logic           w_wrEn;
    logic [DW-1:0]  w_wrData;

    logic           w_rdEn;
    logic [NW-1:0]  r_rdIdx;
    logic [RW-1:0]  r_rdRow;
    logic [CLW-1:0] r_rdCol;
    logic [NW-1:0]  w_rdIdxCur;
    logic [RW-1:0]  w_rdRowCur;
    logic [CLW-1:0] w_rdColCur;
    logic [NW-1:0]  w_rdIdxNext;
    logic [RW-1:0]  w_rdRowNext;
    logic [CLW-1:0] w_rdColNext;
    logic [DW-1:0]  w_rdData;

    logic           r_qValid;
    logic           r_qLast;
    logic [RW-1:0]  r_qRow;
    logic [CLW-1:0] r_qCol;

    logic           r_outValid;
    logic           r_outLast;
    logic [DW-1:0]  r_outData;
    logic [RW-1:0]  r_outRow;
    logic [CLW-1:0] r_outCol;

    logic           w_accept;
    logic           w_load;

`ifdef CONV_RES_CLIP_EN
    localparam logic signed [DW-1:0] CLIP_MAX = DW'(127);
    localparam logic signed [DW-1:0] CLIP_MIN = DW'(-128);

    function automatic logic [DW-1:0] clipSample(input logic [DW-1:0] v);
        if ($signed(v) > CLIP_MAX) begin
            return CLIP_MAX;
        end
        if ($signed(v) < CLIP_MIN) begin
            return CLIP_MIN;
        end
        return v;
    endfunction

    assign w_wrData = clipSample(in_data);
`else
    assign w_wrData = in_data;
`endif

    assign w_countInc = r_count + NW'(1);
    assign w_accept   = r_outValid && out_ready;
    assign w_load     = r_qValid && (!r_outValid || out_ready);

    // Read position in effect this cycle; outside DUMP a replay always starts at element 0.
    always_comb begin
        w_rdIdxCur = '0;
        w_rdRowCur = '0;
        w_rdColCur = '0;
        if (r_state == ST_DUMP) begin
            w_rdIdxCur = r_rdIdx;
            w_rdRowCur = r_rdRow;
            w_rdColCur = r_rdCol;
        end
    end

    // Step the read index and its row/column tags; the column wraps and bumps the row.
    always_comb begin
        w_rdIdxNext = w_rdIdxCur + NW'(1);
        w_rdRowNext = w_rdRowCur;
        w_rdColNext = w_rdColCur + CLW'(1);
        if (w_rdColCur == COL_LAST) begin
            w_rdColNext = '0;
            w_rdRowNext = w_rdRowCur + RW'(1);
        end
    end

    // Next state, buffer write/read strobes and sticky flag set requests; clr overrides all.
    always_comb begin
        w_stateNext   = r_state;
        w_wrEn        = 1'b0;
        w_rdEn        = 1'b0;
        w_setShort    = 1'b0;
        w_setOverflow = 1'b0;
        case (r_state)
            ST_IDLE, ST_CAPTURE: begin
                if (in_valid) begin
                    w_wrEn = 1'b1;
                    if (w_countInc == DEPTH_N) begin
                        w_stateNext = ST_FULL;
                    end else if (in_done) begin
                        w_stateNext = ST_FULL;
                        w_setShort  = 1'b1;
                    end else begin
                        w_stateNext = ST_CAPTURE;
                    end
                end else if (in_done && (r_state == ST_CAPTURE)) begin
                    w_stateNext = ST_FULL;
                    w_setShort  = 1'b1;
                end
            end
            ST_FULL: begin
                w_setOverflow = in_valid;
                if (start_dump) begin
                    w_stateNext = ST_DUMP;
                    w_rdEn      = 1'b1;
                end
            end
            ST_DUMP: begin
                w_setOverflow = in_valid;
                w_rdEn        = (r_rdIdx < r_count) && (!r_qValid || w_load);
                if (w_accept && r_outLast) begin
                    w_stateNext = ST_FULL;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
        if (clr) begin
            w_stateNext   = ST_IDLE;
            w_wrEn        = 1'b0;
            w_rdEn        = 1'b0;
            w_setShort    = 1'b0;
            w_setOverflow = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Capture count, which is also the buffer write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_wrEn) begin
            r_count <= w_countInc;
        end
    end

    // Sticky short-frame and overflow flags, cleared only by reset or clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shortFrame <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (clr) begin
            r_shortFrame <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_setShort) begin
                r_shortFrame <= 1'b1;
            end
            if (w_setOverflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Read index and row/column counters; parked at zero whenever no replay is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdIdx <= '0;
            r_rdRow <= '0;
            r_rdCol <= '0;
        end else if (clr) begin
            r_rdIdx <= '0;
            r_rdRow <= '0;
            r_rdCol <= '0;
        end else if (w_rdEn) begin
            r_rdIdx <= w_rdIdxNext;
            r_rdRow <= w_rdRowNext;
            r_rdCol <= w_rdColNext;
        end else if (r_state != ST_DUMP) begin
            r_rdIdx <= '0;
            r_rdRow <= '0;
            r_rdCol <= '0;
        end
    end

    // Tags travelling alongside the RAM read register (stage 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qValid <= 1'b0;
            r_qLast  <= 1'b0;
            r_qRow   <= '0;
            r_qCol   <= '0;
        end else if (clr) begin
            r_qValid <= 1'b0;
            r_qLast  <= 1'b0;
            r_qRow   <= '0;
            r_qCol   <= '0;
        end else if (w_rdEn) begin
            r_qValid <= 1'b1;
            r_qLast  <= (w_rdIdxCur == (r_count - NW'(1)));
            r_qRow   <= w_rdRowCur;
            r_qCol   <= w_rdColCur;
        end else if (w_load) begin
            r_qValid <= 1'b0;
        end
    end

    // Output register (stage 2): loads when empty or accepted, otherwise holds stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
            r_outRow   <= '0;
            r_outCol   <= '0;
        end else if (clr) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
            r_outRow   <= '0;
            r_outCol   <= '0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            r_outLast  <= r_qLast;
            r_outData  <= w_rdData;
            r_outRow   <= r_qRow;
            r_outCol   <= r_qCol;
        end else if (w_accept) begin
            r_outValid <= 1'b0;
        end
    end

    conv_res_collector_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .i_clk    (clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (r_count[AW-1:0]),
        .i_wrData (w_wrData),
        .i_rdEn   (w_rdEn),
        .i_rdAddr (w_rdIdxCur[AW-1:0]),
        .o_rdData (w_rdData)
    );

    assign out_data    = r_outData;
    assign out_row     = r_outRow;
    assign out_col     = r_outCol;
    assign out_valid   = r_outValid;
    assign out_last    = r_outLast;
    assign frame_rdy   = (r_state == ST_FULL);
    assign count       = r_count;
    assign short_frame = r_shortFrame;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_conv_res_collector.sv
// Self-checking bench for conv_res_collector. A frame-level model (sample
// queue, replay index, sticky flags) predicts every status and replay output;
// a negedge compare process checks the DUT against it each cycle, and directed
// literal checks pin the model to hand-computed values.
module tb_conv_res_collector;

   localparam int ROWS  = 8;
   localparam int COLS  = 10;
   localparam int DW    = 16;
   localparam int FRAME = ROWS * COLS;

   localparam int PH_IDLE    = 0;
   localparam int PH_CAPTURE = 1;
   localparam int PH_FULL    = 2;
   localparam int PH_DUMP    = 3;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          clr        = 1'b0;
   logic [DW-1:0] in_data    = '0;
   logic          in_valid   = 1'b0;
   logic          in_done    = 1'b0;
   logic          start_dump = 1'b0;
   logic          out_ready  = 1'b0;
   logic [DW-1:0] out_data;
   logic [2:0]    out_row;
   logic [3:0]    out_col;
   logic          out_valid;
   logic          out_last;
   logic          frame_rdy;
   logic [6:0]    count;
   logic          short_frame;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   int mdlBuf[$];
   int mdlPhase = PH_IDLE;
   int mdlIdx   = 0;
   int mdlWait  = 0;
   bit mdlShort = 1'b0;
   bit mdlOvf   = 1'b0;

   int beatData[$];
   int beatRow[$];
   int beatCol[$];
   int lastCount = 0;
   int lastRow   = -1;
   int lastCol   = -1;

   conv_res_collector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_done     (in_done),
      .start_dump  (start_dump),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .frame_rdy   (frame_rdy),
      .count       (count),
      .short_frame (short_frame),
      .overflow    (overflow)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Runaway guard so the bench can never hang
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Sample value as the collector should store it
   function automatic int mdlClip(input int v);
`ifdef CONV_RES_CLIP_EN
      if (v > 127) return 127;
      if (v < -128) return -128;
`endif
      return v;
   endfunction

   // Single comparison with pass/fail bookkeeping
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge
   task automatic applyStimulus(input logic v, input int d, input logic done,
                                input logic sd, input logic rdy, input logic c);
      @(negedge clk);
      #1;
      in_valid   = v;
      in_data    = DW'(d);
      in_done    = done;
      start_dump = sd;
      out_ready  = rdy;
      clr        = c;
   endtask

   task automatic clearBeats();
      beatData.delete();
      beatRow.delete();
      beatCol.delete();
      lastCount = 0;
      lastRow   = -1;
      lastCol   = -1;
   endtask

   // Request a replay and drain it, optionally with random backpressure
   task automatic runDump(input bit randomReady, input int expBeats);
      logic rdy;
      clearBeats();
      applyStimulus(0, 0, 0, 1, 1'b1, 0);
      for (int i = 0; i < 1000; i++) begin
         if (beatData.size() == expBeats && frame_rdy) break;
         rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         applyStimulus(0, 0, 0, 0, rdy, 0);
      end
      checkOutput("dumpBeats", beatData.size(), expBeats);
      checkOutput("dumpLastCount", lastCount, 1);
   endtask

   // Frame-level model plus a log of every beat the DUT hands over
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdlBuf.delete();
         mdlPhase = PH_IDLE;
         mdlIdx   = 0;
         mdlWait  = 0;
         mdlShort = 1'b0;
         mdlOvf   = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            beatData.push_back(int'($signed(out_data)));
            beatRow.push_back(int'(out_row));
            beatCol.push_back(int'(out_col));
            if (out_last) begin
               lastCount++;
               lastRow = int'(out_row);
               lastCol = int'(out_col);
            end
         end
         if (clr) begin
            mdlBuf.delete();
            mdlPhase = PH_IDLE;
            mdlIdx   = 0;
            mdlWait  = 0;
            mdlShort = 1'b0;
            mdlOvf   = 1'b0;
         end else begin
            case (mdlPhase)
               PH_IDLE, PH_CAPTURE: begin
                  if (in_valid) begin
                     mdlBuf.push_back(mdlClip(int'($signed(in_data))));
                     mdlPhase = PH_CAPTURE;
                  end
                  if (mdlBuf.size() == FRAME) begin
                     mdlPhase = PH_FULL;
                  end else if (in_done && mdlBuf.size() > 0) begin
                     mdlPhase = PH_FULL;
                     mdlShort = 1'b1;
                  end
               end
               PH_FULL: begin
                  if (in_valid) mdlOvf = 1'b1;
                  if (start_dump) begin
                     mdlPhase = PH_DUMP;
                     mdlIdx   = 0;
                     mdlWait  = 1;
                  end
               end
               default: begin
                  if (in_valid) mdlOvf = 1'b1;
                  if (mdlWait > 0) begin
                     mdlWait--;
                  end else if (out_ready) begin
                     mdlIdx++;
                     if (mdlIdx == mdlBuf.size()) mdlPhase = PH_FULL;
                  end
               end
            endcase
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("count", int'(count), mdlBuf.size());
         checkOutput("frame_rdy", int'(frame_rdy), (mdlPhase == PH_FULL) ? 1 : 0);
         checkOutput("short_frame", int'(short_frame), int'(mdlShort));
         checkOutput("overflow", int'(overflow), int'(mdlOvf));
         checkOutput("out_valid", int'(out_valid),
                     (mdlPhase == PH_DUMP && mdlWait == 0) ? 1 : 0);
         if (mdlPhase == PH_DUMP && mdlWait == 0) begin
            checkOutput("out_data", int'($signed(out_data)), mdlBuf[mdlIdx]);
            checkOutput("out_row", int'(out_row), mdlIdx / COLS);
            checkOutput("out_col", int'(out_col), mdlIdx % COLS);
            checkOutput("out_last", int'(out_last), (mdlIdx == mdlBuf.size() - 1) ? 1 : 0);
         end
      end
   end

   // Directed test sequence
   initial begin
      int orderErrs;
      int exp0;
      int exp1;

      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("resetCount", int'(count), 0);
      checkOutput("resetFrameRdy", int'(frame_rdy), 0);
      checkOutput("resetOutValid", int'(out_valid), 0);

      $display("[TB] full frame capture");
      for (int i = 0; i < FRAME; i++) applyStimulus(1, i - 40, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("fullCount", int'(count), 80);
      checkOutput("fullFrameRdy", int'(frame_rdy), 1);
      checkOutput("fullShort", int'(short_frame), 0);
      checkOutput("fullOverflow", int'(overflow), 0);

      $display("[TB] replay at full throughput");
      clearBeats();
      applyStimulus(0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("latencyCycle1", int'(out_valid), 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("latencyCycle2", int'(out_valid), 1);
      checkOutput("firstData", int'($signed(out_data)), -40);
      checkOutput("firstRow", int'(out_row), 0);
      checkOutput("firstCol", int'(out_col), 0);
      for (int i = 0; i < 200; i++) begin
         if (beatData.size() == FRAME && frame_rdy) break;
         applyStimulus(0, 0, 0, 0, 1, 0);
      end
      checkOutput("replayBeats", beatData.size(), 80);
      checkOutput("replayLastCount", lastCount, 1);
      checkOutput("replayLastRow", lastRow, 7);
      checkOutput("replayLastCol", lastCol, 9);
      if (beatData.size() == FRAME) begin
         checkOutput("replayFinalData", beatData[79], 39);
         checkOutput("replayMidRow", beatRow[45], 4);
         checkOutput("replayMidCol", beatCol[45], 5);
      end

      $display("[TB] replay with random backpressure");
      runDump(1'b1, FRAME);
      orderErrs = 0;
      foreach (beatData[i]) if (beatData[i] != i - 40) orderErrs++;
      checkOutput("stallReplayOrder", orderErrs, 0);

      $display("[TB] overflow and re-dump");
      for (int i = 0; i < 3; i++) applyStimulus(1, 999, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("ovfFlag", int'(overflow), 1);
      checkOutput("ovfCount", int'(count), 80);
      runDump(1'b0, FRAME);
      if (beatData.size() == FRAME) checkOutput("redumpData5", beatData[5], -35);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("clrCount", int'(count), 0);
      checkOutput("clrOverflow", int'(overflow), 0);
      checkOutput("clrShort", int'(short_frame), 0);
      checkOutput("clrFrameRdy", int'(frame_rdy), 0);

      $display("[TB] short frame");
      for (int i = 0; i < 30; i++) applyStimulus(1, 2 * i - 25, (i == 29) ? 1'b1 : 1'b0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("shortCount", int'(count), 30);
      checkOutput("shortFlag", int'(short_frame), 1);
      checkOutput("shortFrameRdy", int'(frame_rdy), 1);
      runDump(1'b1, 30);
      checkOutput("shortLastRow", lastRow, 2);
      checkOutput("shortLastCol", lastCol, 9);
      if (beatData.size() == 30) checkOutput("shortLastData", beatData[29], 33);

      $display("[TB] reset during replay");
      applyStimulus(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("validBeforeReset", int'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("resetMidDumpValid", int'(out_valid), 0);
      checkOutput("resetMidDumpCount", int'(count), 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      $display("[TB] sample range handling");
      applyStimulus(1, 300, 0, 0, 0, 0);
      applyStimulus(1, -200, 0, 0, 0, 0);
      applyStimulus(1, 5, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rangeCount", int'(count), 3);
      checkOutput("rangeShort", int'(short_frame), 1);
      runDump(1'b0, 3);
`ifdef CONV_RES_CLIP_EN
      exp0 = 127;
      exp1 = -128;
`else
      exp0 = 300;
      exp1 = -200;
`endif
      if (beatData.size() == 3) begin
         checkOutput("rangeData0", beatData[0], exp0);
         checkOutput("rangeData1", beatData[1], exp1);
         checkOutput("rangeData2", beatData[2], 5);
      end

      applyStimulus(0, 0, 0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
